// File: rtl/counter_read_ctrl_if.sv
// Read-side bus of the counters sequencer: requester handshake plus the shared
// counters read port. The controller uses the master modport.
interface counter_read_ctrl_if #(
    parameter int NREQ  = 2,
    parameter int IDX_W = 3,
    parameter int CNT_W = 5
);
    logic [NREQ-1:0]       rd_req;
    logic [NREQ*IDX_W-1:0] rd_idx;
    logic [NREQ-1:0]       rd_gnt;
    logic [NREQ-1:0]       rd_valid;
    logic [CNT_W-1:0]      rd_data;
    logic                  rd_err;
    logic                  cnt_req;
    logic [IDX_W-1:0]      cnt_idx;
    logic [CNT_W-1:0]      counts;

    modport master (
        input  rd_req, rd_idx, counts,
        output rd_gnt, rd_valid, rd_data, rd_err, cnt_req, cnt_idx
    );

    modport slave (
        output rd_req, rd_idx, counts,
        input  rd_gnt, rd_valid, rd_data, rd_err, cnt_req, cnt_idx
    );
endinterface

// File: rtl/counter_read_ctrl.sv
// Counters sequencer (RESET/INIT/IDLE/ACTIVE) and round-robin arbiter sharing
// the single counters read port among NREQ requesters.
module counter_read_ctrl #(
    parameter int NREQ    = 2,
    parameter int NUM_CNT = 5,
    parameter int IDX_W   = 3,
    parameter int CNT_W   = 5
) (
    input  logic                clk,
    input  logic                reset_L,
    input  logic                init,
    input  logic                fifo_empty,
    counter_read_ctrl_if.master bus,
    output logic [3:0]          state,
    output logic                idle
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    localparam logic [3:0] S_RESET  = 4'b0001;
    localparam logic [3:0] S_INIT   = 4'b0010;
    localparam logic [3:0] S_IDLE   = 4'b0100;
    localparam logic [3:0] S_ACTIVE = 4'b1000;

    logic [3:0]       state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [NREQ-1:0]  rd_gnt_q, rd_gnt_d;
    logic [NREQ-1:0]  rd_valid_q, rd_valid_d;
    logic             cnt_req_q, cnt_req_d;
    logic [IDX_W-1:0] cnt_idx_q, cnt_idx_d;
    logic             wait_q, wait_d;
    logic             err_q, err_d;
    logic             rd_err_q, rd_err_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;

    logic [PTR_W-1:0] winner;
    logic [PTR_W-1:0] cand;
    logic [IDX_W-1:0] win_idx;
    logic             idx_bad;
    logic             grant_en;

    // ---------------- sequencer FSM ----------------
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) state_q <= S_RESET;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:  state_d = S_INIT;
            S_INIT:   if (!init) state_d = S_IDLE;
            S_IDLE:   if (init) state_d = S_INIT;
                      else if (!fifo_empty) state_d = S_ACTIVE;
            S_ACTIVE: if (init) state_d = S_INIT;
                      else if (fifo_empty) state_d = S_IDLE;
            default:  state_d = S_RESET;
        endcase
    end

    always_comb begin
        state = state_q;
        idle  = (state_q == S_IDLE);
    end

    // ---------------- round-robin arbiter ----------------
    // Scan downwards so the requester closest after the pointer is the last hit.
    always_comb begin
        winner = ptr_q;
        cand   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = PTR_W'((int'(ptr_q) + k) % NREQ);
            if (bus.rd_req[cand]) winner = cand;
        end
    end

    assign win_idx = bus.rd_idx[winner*IDX_W +: IDX_W];
    assign idx_bad = (int'(win_idx) >= NUM_CNT);

    // Grant only if the FSM also stays in IDLE across this edge; a read slot is
    // free again on the edge that captures the previous read's data.
    assign grant_en = (state_q == S_IDLE) && !init && fifo_empty &&
                      (rd_gnt_q == '0) && (|bus.rd_req);

    always_comb begin
        ptr_d      = ptr_q;
        cnt_idx_d  = cnt_idx_q;
        err_d      = err_q;
        rd_data_d  = rd_data_q;
        rd_gnt_d   = '0;
        cnt_req_d  = 1'b0;
        rd_valid_d = '0;
        rd_err_d   = 1'b0;
        wait_d     = |rd_gnt_q;

        // ptr_q still names the winner of the read whose data arrives now.
        if (wait_q) begin
            rd_valid_d = ONE << ptr_q;
            rd_err_d   = err_q;
            rd_data_d  = err_q ? '0 : bus.counts;
        end

        if (grant_en) begin
            ptr_d     = winner;
            rd_gnt_d  = ONE << winner;
            cnt_idx_d = win_idx;
            err_d     = idx_bad;
            cnt_req_d = !idx_bad;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            ptr_q      <= PTR_W'(NREQ - 1);
            rd_gnt_q   <= '0;
            rd_valid_q <= '0;
            cnt_req_q  <= 1'b0;
            cnt_idx_q  <= '0;
            wait_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            ptr_q      <= ptr_d;
            rd_gnt_q   <= rd_gnt_d;
            rd_valid_q <= rd_valid_d;
            cnt_req_q  <= cnt_req_d;
            cnt_idx_q  <= cnt_idx_d;
            wait_q     <= wait_d;
            err_q      <= err_d;
            rd_err_q   <= rd_err_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign bus.rd_gnt   = rd_gnt_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_err   = rd_err_q;
    assign bus.cnt_req  = cnt_req_q;
    assign bus.cnt_idx  = cnt_idx_q;

endmodule

// File: tb/tb_counter_read_ctrl.sv
// Bench for counter_read_ctrl: directed scenarios plus a randomized run scored
// against a transaction-level model of the sequencer and arbiter.
module tb_counter_read_ctrl;

    localparam int NREQ    = 2;
    localparam int NUM_CNT = 5;
    localparam int IDX_W   = 3;
    localparam int CNT_W   = 5;

    typedef struct {
        int         who;
        logic [4:0] data;
        bit         err;
        int         due;
    } rd_t;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic       init = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [3:0] state;
    logic       idle;
    logic [1:0] req = '0;
    logic [2:0] idxa [2];
    logic [4:0] mem [0:7];

    int vec  = 0;
    int miss = 0;

    counter_read_ctrl_if #(.NREQ(NREQ), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

    counter_read_ctrl #(.NREQ(NREQ), .NUM_CNT(NUM_CNT), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .init       (init),
        .fifo_empty (fifo_empty),
        .bus        (bus),
        .state      (state),
        .idle       (idle)
    );

    assign bus.rd_req = req;
    assign bus.rd_idx = {idxa[1], idxa[0]};

    always #5 clk = ~clk;

    // Counters block: data appears one cycle after cnt_req, junk otherwise.
    always @(posedge clk) bus.counts <= bus.cnt_req ? mem[bus.cnt_idx] : 5'($urandom);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_L = 1'b0; init = 1'b0; fifo_empty = 1'b1; req = '0;
        tick();
        reset_L = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset_L = 1'b0; init = 1'b0; fifo_empty = 1'b1; req = '0;
        repeat (2) tick();
        vec++; if (state !== 4'b0001) begin miss++; $display("FAIL reset_state: got %b expected 0001", state); end
        vec++; if (idle !== 1'b0) begin miss++; $display("FAIL reset_idle: got %b expected 0", idle); end
        vec++; if (bus.cnt_req !== 1'b0 || bus.cnt_idx !== 3'd0) begin miss++; $display("FAIL reset_cnt: got req=%b idx=%0d expected 0/0", bus.cnt_req, bus.cnt_idx); end
        vec++; if (bus.rd_gnt !== 2'b00 || bus.rd_valid !== 2'b00) begin miss++; $display("FAIL reset_gnt_valid: got %b/%b expected 00/00", bus.rd_gnt, bus.rd_valid); end
        vec++; if (bus.rd_data !== 5'd0 || bus.rd_err !== 1'b0) begin miss++; $display("FAIL reset_data: got %0d/%b expected 0/0", bus.rd_data, bus.rd_err); end
    endtask

    task automatic test_startup();
        reset_L = 1'b1;
        tick();
        vec++; if (state !== 4'b0010) begin miss++; $display("FAIL startup_init: got %b expected 0010", state); end
        tick();
        vec++; if (state !== 4'b0100 || idle !== 1'b1) begin miss++; $display("FAIL startup_idle: got %b idle=%b expected 0100 idle=1", state, idle); end
        $display("startup: state sequence checked");
    endtask

    task automatic test_single_read();
        req = 2'b01; idxa[0] = 3'd2;
        tick();
        vec++; if (bus.cnt_req !== 1'b1 || bus.cnt_idx !== 3'd2 || bus.rd_gnt !== 2'b01) begin miss++; $display("FAIL single_grant: got req=%b idx=%0d gnt=%b expected 1/2/01", bus.cnt_req, bus.cnt_idx, bus.rd_gnt); end
        req = 2'b00;
        tick();
        vec++; if (bus.cnt_req !== 1'b0 || bus.rd_gnt !== 2'b00 || bus.rd_valid !== 2'b00) begin miss++; $display("FAIL single_e1: got req=%b gnt=%b valid=%b expected 0/00/00", bus.cnt_req, bus.rd_gnt, bus.rd_valid); end
        tick();
        vec++; if (bus.rd_valid !== 2'b01 || bus.rd_data !== 5'd7 || bus.rd_err !== 1'b0) begin miss++; $display("FAIL single_valid: got valid=%b data=%0d err=%b expected 01/7/0", bus.rd_valid, bus.rd_data, bus.rd_err); end
        tick();
        vec++; if (bus.rd_valid !== 2'b00 || bus.rd_data !== 5'd7) begin miss++; $display("FAIL single_hold: got valid=%b data=%0d expected 00/7", bus.rd_valid, bus.rd_data); end
        $display("single read: req0 idx 2 -> data 7");
    endtask

    task automatic test_round_robin();
        logic [1:0] prev, exp_g;
        logic [2:0] exp_i;
        do_reset();
        idxa[0] = 3'd1; idxa[1] = 3'd3; req = 2'b11;
        prev = 2'b00;
        for (int g = 0; g < 4; g++) begin
            tick();
            exp_g = (g % 2 == 0) ? 2'b01 : 2'b10;
            exp_i = (g % 2 == 0) ? 3'd1 : 3'd3;
            vec++; if (bus.rd_gnt !== exp_g || bus.cnt_idx !== exp_i || bus.cnt_req !== 1'b1) begin miss++; $display("FAIL rr_grant%0d: got gnt=%b idx=%0d req=%b expected %b/%0d/1", g, bus.rd_gnt, bus.cnt_idx, bus.cnt_req, exp_g, exp_i); end
            vec++; if (bus.rd_valid !== prev) begin miss++; $display("FAIL rr_valid%0d: got %b expected %b", g, bus.rd_valid, prev); end
            if (prev != 2'b00) begin
                vec++; if (bus.rd_data !== mem[(prev == 2'b01) ? 1 : 3]) begin miss++; $display("FAIL rr_data%0d: got %0d expected %0d", g, bus.rd_data, mem[(prev == 2'b01) ? 1 : 3]); end
            end
            prev = exp_g;
            tick();
            vec++; if (bus.rd_gnt !== 2'b00) begin miss++; $display("FAIL rr_gap%0d: got %b expected 00", g, bus.rd_gnt); end
            $display("rr: grant %b idx %0d", exp_g, exp_i);
        end
        req = 2'b00;
        tick();
        vec++; if (bus.rd_valid !== 2'b10 || bus.rd_data !== mem[3]) begin miss++; $display("FAIL rr_last: got %b/%0d expected 10/%0d", bus.rd_valid, bus.rd_data, mem[3]); end
    endtask

    task automatic test_active_hold();
        fifo_empty = 1'b0; req = 2'b01; idxa[0] = 3'd0;
        tick();
        vec++; if (state !== 4'b1000 || bus.rd_gnt !== 2'b00) begin miss++; $display("FAIL active_enter: got %b gnt=%b expected 1000/00", state, bus.rd_gnt); end
        tick();
        vec++; if (state !== 4'b1000 || bus.rd_gnt !== 2'b00) begin miss++; $display("FAIL active_stay: got %b gnt=%b expected 1000/00", state, bus.rd_gnt); end
        fifo_empty = 1'b1;
        tick();
        vec++; if (state !== 4'b0100 || bus.rd_gnt !== 2'b00) begin miss++; $display("FAIL active_exit: got %b gnt=%b expected 0100/00", state, bus.rd_gnt); end
        tick();
        vec++; if (bus.rd_gnt !== 2'b01 || bus.cnt_idx !== 3'd0 || bus.cnt_req !== 1'b1) begin miss++; $display("FAIL active_grant: got %b/%0d/%b expected 01/0/1", bus.rd_gnt, bus.cnt_idx, bus.cnt_req); end
        req = 2'b00;
        tick();
        tick();
        vec++; if (bus.rd_valid !== 2'b01 || bus.rd_data !== mem[0]) begin miss++; $display("FAIL active_valid: got %b/%0d expected 01/%0d", bus.rd_valid, bus.rd_data, mem[0]); end
        $display("active hold: pending req0 granted after return to IDLE");
    endtask

    task automatic test_bad_idx();
        req = 2'b10; idxa[1] = 3'd6;
        tick();
        vec++; if (bus.rd_gnt !== 2'b10 || bus.cnt_req !== 1'b0) begin miss++; $display("FAIL badidx_grant: got gnt=%b req=%b expected 10/0", bus.rd_gnt, bus.cnt_req); end
        req = 2'b00;
        tick();
        vec++; if (bus.cnt_req !== 1'b0) begin miss++; $display("FAIL badidx_noreq: got %b expected 0", bus.cnt_req); end
        tick();
        vec++; if (bus.rd_valid !== 2'b10 || bus.rd_err !== 1'b1 || bus.rd_data !== 5'd0) begin miss++; $display("FAIL badidx_valid: got %b err=%b data=%0d expected 10/1/0", bus.rd_valid, bus.rd_err, bus.rd_data); end
        tick();
        vec++; if (bus.rd_valid !== 2'b00 || bus.rd_err !== 1'b0) begin miss++; $display("FAIL badidx_after: got %b err=%b expected 00/0", bus.rd_valid, bus.rd_err); end
        $display("bad idx: req1 idx 6 -> err");
    endtask

    task automatic test_reset_inflight();
        req = 2'b01; idxa[0] = 3'd4;
        tick();
        vec++; if (bus.rd_gnt !== 2'b01) begin miss++; $display("FAIL rst_pre_grant: got %b expected 01", bus.rd_gnt); end
        req = 2'b00;
        #2;
        reset_L = 1'b0;
        #1;
        vec++; if (state !== 4'b0001 || idle !== 1'b0) begin miss++; $display("FAIL rst_async_state: got %b idle=%b expected 0001/0", state, idle); end
        vec++; if (bus.rd_gnt !== 2'b00 || bus.cnt_req !== 1'b0 || bus.rd_valid !== 2'b00 || bus.rd_data !== 5'd0 || bus.rd_err !== 1'b0) begin miss++; $display("FAIL rst_async_out: got gnt=%b req=%b valid=%b data=%0d err=%b expected all 0", bus.rd_gnt, bus.cnt_req, bus.rd_valid, bus.rd_data, bus.rd_err); end
        tick();
        reset_L = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            vec++; if (bus.rd_valid !== 2'b00) begin miss++; $display("FAIL rst_no_valid%0d: got %b expected 00", c, bus.rd_valid); end
        end
        $display("reset in flight: read discarded");
    endtask

    task automatic test_random();
        int         st, ptr, n, w;
        bit         gnt_prev, found;
        logic       in_init, in_fe;
        logic [1:0] in_req, exp_gnt, exp_valid;
        logic [2:0] exp_cidx;
        logic       exp_creq, exp_err;
        logic [4:0] exp_data;
        rd_t        q[$];
        rd_t        r;
        do_reset();
        st = 2; ptr = NREQ - 1; n = 0; gnt_prev = 1'b0; exp_data = 5'd0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            init       = ($urandom_range(0, 19) == 0);
            fifo_empty = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    idxa[i] = 3'($urandom_range(0, 7));
                    req[i]  = 1'b1;
                end
            end
            in_init = init; in_fe = fifo_empty; in_req = req;
            tick();
            n++;

            exp_gnt = 2'b00; exp_creq = 1'b0; exp_cidx = 3'd0; exp_valid = 2'b00; exp_err = 1'b0;
            if (st == 2 && !in_init && in_fe && !gnt_prev && in_req != 2'b00) begin
                found = 1'b0; w = ptr;
                for (int k = 1; k <= NREQ; k++) begin
                    if (!found && in_req[(ptr + k) % NREQ]) begin
                        w = (ptr + k) % NREQ;
                        found = 1'b1;
                    end
                end
                ptr      = w;
                exp_gnt  = 2'(1 << w);
                exp_cidx = idxa[w];
                exp_creq = (int'(idxa[w]) < NUM_CNT);
                r.who = w; r.err = !exp_creq; r.data = exp_creq ? mem[idxa[w]] : 5'd0; r.due = n + 2;
                q.push_back(r);
                gnt_prev = 1'b1;
            end else begin
                gnt_prev = 1'b0;
            end
            if (q.size() > 0 && q[0].due == n) begin
                r = q.pop_front();
                exp_valid = 2'(1 << r.who);
                exp_data  = r.data;
                exp_err   = r.err;
            end
            case (st)
                0: st = 1;
                1: st = in_init ? 1 : 2;
                2: st = in_init ? 1 : (!in_fe ? 3 : 2);
                default: st = in_init ? 1 : (in_fe ? 2 : 3);
            endcase

            vec++; if (state !== 4'(1 << st) || idle !== (st == 2)) begin miss++; $display("FAIL rnd_state@%0d: got %b idle=%b expected %b", cyc, state, idle, 4'(1 << st)); end
            vec++; if (bus.rd_gnt !== exp_gnt || bus.cnt_req !== exp_creq) begin miss++; $display("FAIL rnd_grant@%0d: got gnt=%b req=%b expected %b/%b", cyc, bus.rd_gnt, bus.cnt_req, exp_gnt, exp_creq); end
            if (exp_gnt != 2'b00) begin
                vec++; if (bus.cnt_idx !== exp_cidx) begin miss++; $display("FAIL rnd_idx@%0d: got %0d expected %0d", cyc, bus.cnt_idx, exp_cidx); end
            end
            vec++; if (bus.rd_valid !== exp_valid || bus.rd_data !== exp_data) begin miss++; $display("FAIL rnd_valid@%0d: got %b/%0d expected %b/%0d", cyc, bus.rd_valid, bus.rd_data, exp_valid, exp_data); end
            if (exp_valid != 2'b00) begin
                vec++; if (bus.rd_err !== exp_err) begin miss++; $display("FAIL rnd_err@%0d: got %b expected %b", cyc, bus.rd_err, exp_err); end
                $display("rnd read: requester %0d data %0d err %0d", r.who, exp_data, exp_err);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (bus.rd_gnt[i]) req[i] = 1'b0;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 5'($urandom);
        mem[2] = 5'd7;
        idxa[0] = 3'd0; idxa[1] = 3'd0;
        test_reset();
        test_startup();
        test_single_read();
        test_round_robin();
        test_active_hold();
        test_bad_idx();
        test_reset_inflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
